// File: rtl/icache_direct_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_direct_if                                                         |
// | Refill bus between icache_direct and instruction memory (req/valid).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface icache_direct_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_direct                                                            |
// | Direct-mapped read-only instruction cache with a one-word-per-beat line  |
// | refill FSM. Define ICACHE_STATS_EN to add hit_cnt/miss_cnt counters.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module icache_direct #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  wire              clk,
  input  wire              rst,
  input  wire       [31:0] pc,
  input  wire              inst_ce,
  input  wire              flush,
  output logic      [31:0] instr,
  output logic             cache_hit,
`ifdef ICACHE_STATS_EN
  output logic      [31:0] hit_cnt,
  output logic      [31:0] miss_cnt,
`endif
  icache_direct_if.master  mem
);

  localparam int c_off_w  = $clog2(WORDS);
  localparam int c_idx_w  = $clog2(LINES);
  localparam int c_line_w = 30 - c_off_w;
  localparam int c_tag_w  = c_line_w - c_idx_w;
  localparam logic [31:0]        c_nop       = 32'h0000_0013;
  localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LINES-1:0]    r_valid;
  logic [c_tag_w-1:0]  r_tag  [LINES];
  logic [31:0]         r_data [LINES][WORDS];
  logic [c_line_w-1:0] r_line;
  logic [c_off_w-1:0]  r_beat;
  logic                r_flushed;

  logic [c_line_w-1:0] w_pc_line;
  logic [c_off_w-1:0]  w_pc_off;
  logic [c_idx_w-1:0]  w_pc_idx;
  logic [c_tag_w-1:0]  w_pc_tag;
  logic [c_idx_w-1:0]  w_fill_idx;
  logic [c_tag_w-1:0]  w_fill_tag;
  logic                w_hit;
  logic                w_start;
  logic                w_beat_ok;
  logic                w_fill_done;
  logic                w_mem_req;
  logic [31:0]         w_mem_addr;
  logic                w_unused;

  assign w_pc_line  = pc[31:c_off_w+2];
  assign w_pc_off   = pc[c_off_w+1:2];
  assign w_pc_idx   = w_pc_line[c_idx_w-1:0];
  assign w_pc_tag   = w_pc_line[c_line_w-1:c_idx_w];
  assign w_fill_idx = r_line[c_idx_w-1:0];
  assign w_fill_tag = r_line[c_line_w-1:c_idx_w];
  assign w_unused   = ^pc[1:0];

  assign w_hit = inst_ce && r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag)
                 && (r_state == IDLE);

  // Disabled fetch reports a hit with a NOP so the core never stalls on it.
  assign cache_hit = !inst_ce || w_hit;
  assign instr     = w_hit ? r_data[w_pc_idx][w_pc_off] : c_nop;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_beat_ok    = 1'b0;
    w_fill_done  = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_addr   = '0;
    case (r_state)
      IDLE: begin
        if (inst_ce && !w_hit) begin
          w_start      = 1'b1;
          w_state_next = REFILL;
        end
      end
      REFILL: begin
        w_mem_req  = 1'b1;
        w_mem_addr = {r_line, r_beat, 2'b00};
        if (mem.mem_valid) begin
          w_beat_ok = 1'b1;
          if (r_beat == c_last_beat) begin
            w_fill_done  = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mem.mem_req  = w_mem_req;
  assign mem.mem_addr = w_mem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_line    <= '0;
      r_valid   <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_line    <= w_pc_line;
        r_beat    <= '0;
        r_flushed <= 1'b0;
      end
      if (w_beat_ok) begin
        r_beat <= r_beat + c_off_w'(1);
      end
      if (flush && (r_state == REFILL)) begin
        r_flushed <= 1'b1;
      end
      if (w_fill_done && !r_flushed && !flush) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      // A flush on the same edge as the last beat must win over the fill.
      if (flush) begin
        r_valid <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat_ok) begin
      r_data[w_fill_idx][r_beat] <= mem.mem_rdata;
    end
    if (w_fill_done) begin
      r_tag[w_fill_idx] <= w_fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_start) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_icache_direct                                                         |
// | Scoreboard bench for icache_direct; memory returns address-as-data.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_icache_direct;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        inst_ce = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        cache_hit;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_direct_if mem_bus ();

  icache_direct #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .inst_ce   (inst_ce),
    .flush     (flush),
    .instr     (instr),
    .cache_hit (cache_hit),
`ifdef ICACHE_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          miss;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] cached[int];
  int          n_vec = 0;
  int          n_err = 0;
  int          mode = 0;
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %08h, required no such event at %0t", name, act, $time);
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  // Memory: mode 0 zero-wait, mode 1 valid every 3rd request cycle, mode 2 random.
  initial begin : memory
    int wcnt;
    bit v;
    wcnt = 0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      v = 1'b0;
      if (rst && mem_bus.mem_req) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (wcnt == 2);
          default: v = ($urandom_range(0, 2) == 0);
        endcase
        wcnt = v ? 0 : wcnt + 1;
      end else begin
        wcnt = 0;
      end
      mem_bus.mem_valid = v;
      mem_bus.mem_rdata = v ? mem_bus.mem_addr : $urandom;
    end
  end

  initial begin : monitor
    int          lowc;
    bit          pend_wait;
    logic [31:0] held;
    exp_t        e;
    lowc = 0;
    pend_wait = 1'b0;
    held = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        lowc = 0;
        pend_wait = 1'b0;
      end else begin
        if (pend_wait && mem_bus.mem_req) chk("addr_hold", mem_bus.mem_addr, held);
        pend_wait = mem_bus.mem_req && !mem_bus.mem_valid;
        held = mem_bus.mem_addr;
        if (mem_bus.mem_req && mem_bus.mem_valid) begin
          if (addr_q.size() == 0) flag("beat_unexpected", mem_bus.mem_addr);
          else chk("beat_addr", mem_bus.mem_addr, addr_q.pop_front());
        end
        if (!inst_ce) begin
          chk("idle_hit", 32'(cache_hit), 32'd1);
          chk("idle_instr", instr, c_nop);
        end else if (!cache_hit) begin
          lowc++;
          chk("miss_instr", instr, c_nop);
        end else begin
          chk("hit_no_req", 32'(mem_bus.mem_req), 32'd0);
          if (exp_q.size() == 0) begin
            flag("hit_unexpected", instr);
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e.instr);
            chk("missed", 32'(lowc > 0), 32'(e.miss));
            if (e.lat >= 0) chk("stall_cycles", 32'(lowc), 32'(e.lat));
          end
          lowc = 0;
        end
      end
    end
  end

  task automatic reset_mid();
    rst = 1'b0;
    inst_ce = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_hit", 32'(cache_hit), 32'd1);
    chk("rst_instr", instr, c_nop);
`ifdef ICACHE_STATS_EN
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
`endif
    exp_q.delete();
    addr_q.delete();
    cached.delete();
    m_hits = 0;
    m_misses = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  // One fetch, held until the hit. flush_beat/rst_beat (0-based, -1 = none)
  // inject a flush or reset during that refill beat.
  task automatic fetch(input logic [31:0] a, input int flush_beat, input int rst_beat);
    logic [31:0] line;
    logic [31:0] base;
    int          idx;
    bit          miss;
    bit          will_flush;
    bit          done;
    bit          flushed;
    int          beats;
    exp_t        e;
    line = a / (4 * WORDS);
    base = line * (4 * WORDS);
    idx = int'(line % LINES);
    miss = !(cached.exists(idx) && cached[idx] == line);
    will_flush = miss && flush_beat >= 0 && flush_beat < WORDS;
    e.instr = {a[31:2], 2'b00};
    e.miss = miss;
    if (!miss) e.lat = 0;
    else if (will_flush || mode == 2) e.lat = -1;
    else if (mode == 0) e.lat = WORDS + 1;
    else e.lat = 1 + 3 * WORDS;
    if (miss) for (int i = 0; i < WORDS; i++) addr_q.push_back(base + 32'(4 * i));
    if (will_flush) for (int i = 0; i < WORDS; i++) addr_q.push_back(base + 32'(4 * i));
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    pc = a;
    inst_ce = 1'b1;
    flush = 1'b0;
    beats = 0;
    done = 1'b0;
    flushed = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (cache_hit) begin
        done = 1'b1;
      end else begin
        if (mem_bus.mem_req && mem_bus.mem_valid) beats++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (mem_bus.mem_req && !flushed && beats == flush_beat) begin
          flush = 1'b1;
          flushed = 1'b1;
        end
        if (mem_bus.mem_req && rst_beat >= 0 && beats == rst_beat) begin
          reset_mid();
          return;
        end
      end
    end
    if (!done) begin
      flag("fetch_timeout", a);
      finish_run();
    end
    if (miss) begin
      m_misses += will_flush ? 2 : 1;
      if (will_flush) cached.delete();
      cached[idx] = line;
    end
    m_hits++;
  endtask

  task automatic idle(input int n, input bit do_flush);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      inst_ce = 1'b0;
      flush = do_flush && (i == 0);
      pc = $urandom;
    end
    if (do_flush) cached.delete();
  endtask

  initial begin : stim
    logic [31:0] tags[4];
    logic [31:0] a;
    int          fb;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hit", 32'(cache_hit), 32'd1);
    chk("reset_instr", instr, c_nop);
    chk("reset_req", 32'(mem_bus.mem_req), 32'd0);
    chk("reset_addr", mem_bus.mem_addr, 32'h0);
    #3 rst = 1'b1;

    mode = 0;
    fetch(32'h100, -1, -1);
    fetch(32'h104, -1, -1);
    fetch(32'h108, -1, -1);
    fetch(32'h10C, -1, -1);
    fetch(32'h500, -1, -1);
    fetch(32'h100, -1, -1);
    mode = 1;
    fetch(32'h200, -1, -1);
    fetch(32'h204, -1, -1);
    mode = 0;
    fetch(32'h300, 1, -1);
    fetch(32'h100, -1, -1);
    fetch(32'h300, -1, -1);
    idle(2, 1'b1);
    fetch(32'h300, -1, -1);
    fetch(32'h600, 3, -1);
    fetch(32'h600, -1, -1);
    fetch(32'h100, -1, 1);
    fetch(32'h100, -1, -1);
    fetch(32'h10C, -1, -1);

    tags[0] = 32'h0;
    for (int i = 1; i < 4; i++) tags[i] = $urandom & 32'hFFFF_FF00;
    for (int n = 0; n < 250; n++) begin
      mode = $urandom_range(0, 2);
      a = tags[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 16)
          + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      fb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WORDS - 1) : -1;
      fetch(a, fb, -1);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3), $urandom_range(0, 3) == 0);
    end
    idle(2, 1'b0);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'(m_hits));
    chk("miss_cnt", miss_cnt, 32'(m_misses));
`endif
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("beats_drained", 32'(addr_q.size()), 32'd0);
    finish_run();
  end

  initial begin : watchdog
    #600000;
    flag("watchdog", 32'(n_vec));
    finish_run();
  end

endmodule
`default_nettype wire
